funct_generator_lut_sequencer: RTL and testbench

//  Sequences reads of funct_generator_lut to play a waveform into the generator FIFO.
//  A phase accumulator produces LUT addresses. Returned samples go through a 4-entry skid buffer so FIFO backpressure never drops a sample.

---
 rtl/funct_generator_lut_sequencer_pkg.sv | 21 ++
 rtl/funct_generator_lut_sequencer_skid_buf.sv | 59 +++++
 rtl/funct_generator_lut_sequencer.sv | 137 +++++++++++++
 tb/tb_funct_generator_lut_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/funct_generator_lut_sequencer_pkg.sv
// Shared types and sizing for the LUT waveform sequencer.
package gen_fifo_defines_pkg;

  // Burst sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Skid buffer depth; also the credit ceiling for in-flight LUT reads.
  localparam int SKID_DEPTH = 4;

  // Occupancy counter width, wide enough to hold 0..SKID_DEPTH.
  localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

  // Credit sum width: occupancy plus two single-bit valid flags.
  localparam int CREDIT_W = SKID_OCC_W + 1;

endpackage

// File: rtl/funct_generator_lut_sequencer_skid_buf.sv
// Small circular FIFO that catches LUT samples returning from the read pipe.
// The issuing side reserves space before reading, so pushes never hit a full buffer.
module gen_lut_skid_buf
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic signed [DATA_WIDTH-1:0] push_data,
  input  logic                         pop,
  output logic signed [DATA_WIDTH-1:0] head_data,
  output logic [SKID_OCC_W-1:0]        occ,
  output logic                         empty
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic signed [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic                         pop_ok;

  // Popping an empty buffer is ignored rather than corrupting the pointers.
  assign pop_ok = pop && !empty;

  // Sample storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_ok})
        2'b10:   occ <= occ + SKID_OCC_W'(1);
        2'b01:   occ <= occ - SKID_OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign empty     = (occ == '0);
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/funct_generator_lut_sequencer.sv
// Phase-accumulator driven LUT reader that streams waveform samples into the
// generator FIFO. Reads are credit-limited against a 4-entry skid buffer so
// FIFO backpressure never loses a sample already requested from the LUT.
module funct_generator_lut_sequencer
  import gen_fifo_defines_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic [PHASE_WIDTH-1:0]       phase_inc_i,
  input  logic [PHASE_WIDTH-1:0]       phase_offset_i,
  input  logic [CNT_WIDTH-1:0]         sample_count_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ADDR_WIDTH-1:0]        read_addr_o,
  input  logic signed [DATA_WIDTH-1:0] read_data_i,
  input  logic                         fifo_full_i,
  output logic                         fifo_wr_en_o,
  output logic signed [DATA_WIDTH-1:0] fifo_wr_data_o
);

  seq_state_t                   state;
  seq_state_t                   state_nxt;

  logic [PHASE_WIDTH-1:0]       acc;
  logic [PHASE_WIDTH-1:0]       inc_r;
  logic [CNT_WIDTH-1:0]         remaining;
  logic                         continuous;

  // v_a: address on read_addr_o this cycle; v_d: LUT data valid this cycle.
  logic                         v_a;
  logic                         v_d;

  logic                         issue;
  logic                         last_issue;
  logic                         credit_ok;
  logic [CREDIT_W-1:0]          credit_used;

  logic                         buf_pop;
  logic                         buf_empty;
  logic [SKID_OCC_W-1:0]        occ;
  logic signed [DATA_WIDTH-1:0] buf_head;

  // Every requested read counts against buffer space until it is popped.
  assign credit_used = CREDIT_W'(occ) + CREDIT_W'(v_a) + CREDIT_W'(v_d);
  assign credit_ok   = (credit_used < CREDIT_W'(SKID_DEPTH));

  // The issue that consumes the last counted sample ends the burst.
  assign last_issue  = issue && !continuous && (remaining == CNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start only matters in IDLE and stop only in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i)                         state_nxt = RUN;
      RUN:   if (stop_i || last_issue)            state_nxt = DRAIN;
      DRAIN: if (!v_a && !v_d && buf_empty)       state_nxt = DONE;
      DONE:                                       state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and the per-cycle read issue decision.
  always_comb begin
    busy_o = (state == RUN) || (state == DRAIN);
    done_o = (state == DONE);
    issue  = (state == RUN) && credit_ok && (continuous || (remaining != '0));
  end

  // Burst configuration capture and phase accumulation / address generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      inc_r       <= '0;
      remaining   <= '0;
      continuous  <= 1'b0;
      read_addr_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      acc         <= phase_offset_i;
      inc_r       <= phase_inc_i;
      remaining   <= sample_count_i;
      continuous  <= (sample_count_i == '0);
    end else if (issue) begin
      read_addr_o <= acc[PHASE_WIDTH-1 -: ADDR_WIDTH];
      acc         <= acc + inc_r;
      if (!continuous) begin
        remaining <= remaining - CNT_WIDTH'(1);
      end
    end
  end

  // Valid pipe tracking reads through the one-cycle LUT latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_a <= 1'b0;
      v_d <= 1'b0;
    end else begin
      v_a <= issue;
      v_d <= v_a;
    end
  end

  assign buf_pop = !buf_empty && !fifo_full_i;

  gen_lut_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (v_d),
    .push_data (read_data_i),
    .pop       (buf_pop),
    .head_data (buf_head),
    .occ       (occ),
    .empty     (buf_empty)
  );

  // Head storage is not reset, so the data port is held at 0 whenever empty.
  assign fifo_wr_en_o   = buf_pop;
  assign fifo_wr_data_o = buf_empty ? '0 : buf_head;

endmodule

// File: tb/tb_funct_generator_lut_sequencer.sv
// Scoreboard bench: each burst pushes its expected sample stream (computed from
// phase arithmetic) into a queue; a monitor pops and compares on every FIFO write.
module tb_funct_generator_lut_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 16;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic                 stop_i = 1'b0;
  logic                 fifo_full_i = 1'b0;
  logic [PW-1:0]        phase_inc_i = '0;
  logic [PW-1:0]        phase_offset_i = '0;
  logic [CW-1:0]        sample_count_i = '0;
  logic                 busy_o;
  logic                 done_o;
  logic                 fifo_wr_en_o;
  logic [AW-1:0]        read_addr_o;
  logic signed [DW-1:0] read_data_i = '0;
  logic signed [DW-1:0] fifo_wr_data_o;

  logic signed [DW-1:0] lut [256];
  logic signed [DW-1:0] exp_q [$];
  int                   checks = 0;
  int                   errors = 0;

  funct_generator_lut_sequencer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PHASE_WIDTH (PW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .phase_inc_i    (phase_inc_i),
    .phase_offset_i (phase_offset_i),
    .sample_count_i (sample_count_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .read_addr_o    (read_addr_o),
    .read_data_i    (read_data_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o)
  );

  always #5 clk = ~clk;

  // LUT model: registered read, data one cycle after the address.
  always @(posedge clk) read_data_i <= lut[read_addr_o];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every FIFO write must match the next expected sample.
  always @(negedge clk) begin
    if (rst_n && fifo_full_i) check("wr_en_while_full", 32'(fifo_wr_en_o), 32'sd0);
    if (rst_n && fifo_wr_en_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0d required=no_write", fifo_wr_data_o);
      end else begin
        check("wr_data", 32'(fifo_wr_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference: sample k of a burst reads LUT entry floor(((off + k*inc) mod 2^16) / 256).
  task automatic expect_burst(input int unsigned off, input int unsigned inc,
                              input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned ph;
      ph = (off + k * inc) % 65536;
      exp_q.push_back(DW'(int'(ph / 256) - 128));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int unsigned off, input int unsigned inc,
                             input int unsigned cnt);
    phase_offset_i = PW'(off);
    phase_inc_i    = PW'(inc);
    sample_count_i = CW'(cnt);
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_full);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else begin
        tick();
        if (rnd_full) fifo_full_i = ($urandom_range(0, 2) == 0);
        n++;
      end
    end
    check("done_seen", 32'(seen), 32'sd1);
    check("busy_during_done", 32'(busy_o), 32'sd0);
    fifo_full_i = 1'b0;
    tick();
    @(negedge clk);
    check("done_one_cycle", 32'(done_o), 32'sd0);
    check("queue_drained", 32'(exp_q.size()), 32'sd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = DW'(i - 128);

    // Reset state
    #2;
    check("rst_busy", 32'(busy_o), 32'sd0);
    check("rst_done", 32'(done_o), 32'sd0);
    check("rst_wr_en", 32'(fifo_wr_en_o), 32'sd0);
    check("rst_addr", 32'(read_addr_o), 32'sd0);
    check("rst_data", 32'(fifo_wr_data_o), 32'sd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: basic burst, address/write latency
    expect_burst(0, 16'h0100, 4);
    start_burst(0, 16'h0100, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) check("t1_busy", 32'(busy_o), 32'sd1);
      if (c >= 2 && c <= 5) check("t1_addr", 32'(read_addr_o), 32'(c - 2));
      check("t1_wr_en", 32'(fifo_wr_en_o), (c >= 4) ? 32'sd1 : 32'sd0);
      tick();
    end
    wait_done(50, 1'b0);

    // 2: accumulator wrap
    expect_burst(16'hFF00, 16'h0100, 3);
    start_burst(16'hFF00, 16'h0100, 3);
    wait_done(50, 1'b0);

    // 3: backpressure stalls issue at the credit limit
    expect_burst(0, 16'h0100, 16);
    start_burst(0, 16'h0100, 16);
    tick();
    tick();
    fifo_full_i = 1'b1;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) check("t3_stalled_addr", 32'(read_addr_o), 32'sd3);
      if (c == 10) check("t3_busy", 32'(busy_o), 32'sd1);
      tick();
    end
    fifo_full_i = 1'b0;
    wait_done(200, 1'b0);

    // 4: continuous mode, stop on the 20th issue cycle
    expect_burst(16'h1234, 16'h0340, 20);
    start_burst(16'h1234, 16'h0340, 0);
    repeat (19) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(100, 1'b0);

    // 5: reset mid-burst with samples buffered
    expect_burst(0, 16'h0100, 16);
    start_burst(0, 16'h0100, 16);
    fifo_full_i = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy_o), 32'sd0);
    check("t5_done", 32'(done_o), 32'sd0);
    check("t5_wr_en", 32'(fifo_wr_en_o), 32'sd0);
    check("t5_addr", 32'(read_addr_o), 32'sd0);
    check("t5_data", 32'(fifo_wr_data_o), 32'sd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    fifo_full_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_idle_busy", 32'(busy_o), 32'sd0);
      check("t5_idle_wr_en", 32'(fifo_wr_en_o), 32'sd0);
      tick();
    end

    // 6: sub-LSB increment; start in RUN and stop in IDLE ignored
    expect_burst(0, 16'h0080, 4);
    start_burst(0, 16'h0080, 4);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(50, 1'b0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_idle_busy", 32'(busy_o), 32'sd0);
      check("t6_idle_wr_en", 32'(fifo_wr_en_o), 32'sd0);
      tick();
    end

    // Randomized bursts with random backpressure
    for (int b = 0; b < 12; b++) begin
      int unsigned off;
      int unsigned inc;
      int unsigned cnt;
      off = $urandom_range(0, 65535);
      inc = (b == 0) ? 0 : $urandom_range(0, 65535);
      cnt = $urandom_range(1, 24);
      expect_burst(off, inc, cnt);
      start_burst(off, inc, cnt);
      fifo_full_i = ($urandom_range(0, 2) == 0);
      wait_done(400, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
